// File: rtl/vend_core_multi.sv
// Purpose: vending controller core with N items, per-item price/stock, credit accumulation and greedy change.
// Latency: vend_valid one cycle after the sel_valid edge; first change coin offered the cycle after VEND or cancel.
// Backpressure: change coins hold code/valid until change_ready; back-to-back coins while change_ready stays high.
module vend_core_multi #(
  parameter int N_ITEMS    = 4,
  parameter int CW         = 8,
  parameter int MAX_CREDIT = 200,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  localparam int IW        = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  coin_valid,
  input  logic [1:0]            coin_code,
  input  logic                  sel_valid,
  input  logic [IW-1:0]         sel_item,
  input  logic                  cancel,
  input  logic                  restock,
  input  logic [N_ITEMS*CW-1:0] price_bus,
  output logic [CW-1:0]         credit,
  output logic                  vend_valid,
  output logic [IW-1:0]         vend_item,
  output logic                  change_valid,
  output logic [1:0]            change_code,
  input  logic                  change_ready,
  output logic                  coin_reject,
  output logic                  sold_out,
  output logic                  short_credit,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  localparam logic [CW:0]      MAX_W    = (CW+1)'(MAX_CREDIT);
  localparam logic [IW:0]      N_W      = (IW+1)'(N_ITEMS);
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  state_t               state;
  logic [STOCK_W-1:0]   stock [N_ITEMS];
  logic [CW-1:0]        price [N_ITEMS];
  logic [CW:0]          coin_sum;
  logic [CW-1:0]        vend_rem;
  logic [CW-1:0]        change_rem;
  logic                 sel_ok;

  // Unit value of a coin code.
  function automatic logic [CW-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = CW'(1);
      2'b01:   coin_value = CW'(5);
      2'b10:   coin_value = CW'(10);
      default: coin_value = CW'(25);
    endcase
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] greedy_code(input logic [CW-1:0] amt);
    if (amt >= CW'(25))      greedy_code = 2'b11;
    else if (amt >= CW'(10)) greedy_code = 2'b10;
    else if (amt >= CW'(5))  greedy_code = 2'b01;
    else                     greedy_code = 2'b00;
  endfunction

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_price
    assign price[i] = price_bus[i*CW +: CW];
  end

  // Sum is one bit wider than credit so an overflowing coin is caught instead of wrapping.
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_value(coin_code)};
  assign vend_rem   = credit - price[vend_item];
  assign change_rem = credit - coin_value(change_code);
  assign sel_ok     = ({1'b0, sel_item} < N_W);

  // Controller FSM: all outputs registered, pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      change_code  <= 2'b00;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
      short_credit <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_INIT;
    end else begin
      vend_valid   <= 1'b0;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
      short_credit <= 1'b0;
      if (ena) begin
        case (state)
          S_IDLE, S_COLLECT: begin
            if (cancel) begin
              // A coin landing with cancel loses to it and is handed back.
              if (coin_valid) coin_reject <= 1'b1;
              if (state == S_COLLECT) begin
                state        <= S_CHANGE;
                busy         <= 1'b1;
                change_valid <= 1'b1;
                change_code  <= greedy_code(credit);
              end
            end else if (sel_valid) begin
              if (coin_valid) coin_reject <= 1'b1;
              if (sel_ok) begin
                if (stock[sel_item] == '0) begin
                  sold_out <= 1'b1;
                end else if (credit < price[sel_item]) begin
                  short_credit <= 1'b1;
                end else begin
                  state      <= S_VEND;
                  busy       <= 1'b1;
                  vend_valid <= 1'b1;
                  vend_item  <= sel_item;
                end
              end
            end else if (coin_valid) begin
              if (coin_sum <= MAX_W) begin
                credit <= coin_sum[CW-1:0];
                state  <= S_COLLECT;
              end else begin
                coin_reject <= 1'b1;
              end
            end
            if (restock && state == S_IDLE) begin
              for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_INIT;
            end
          end
          S_VEND: begin
            if (coin_valid) coin_reject <= 1'b1;
            if (stock[vend_item] != '0) stock[vend_item] <= stock[vend_item] - STOCK_W'(1);
            credit <= vend_rem;
            if (vend_rem != '0) begin
              state        <= S_CHANGE;
              change_valid <= 1'b1;
              change_code  <= greedy_code(vend_rem);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_CHANGE: begin
            if (coin_valid) coin_reject <= 1'b1;
            if (change_ready && change_valid) begin
              credit <= change_rem;
              if (change_rem == '0) begin
                change_valid <= 1'b0;
                state        <= S_IDLE;
                busy         <= 1'b0;
              end else begin
                change_code <= greedy_code(change_rem);
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
